// File: rtl/alu_control_sequencer.sv
// Control sequencer for the single-bus datapath: runs fetch (T0-T2) and executes
// register-register and unary ALU instructions (T3-T5) by decoding ir.
module alu_control_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        pc_out,
    output logic        zlow_out,
    output logic        mdr_out,
    output logic        mar_in,
    output logic        pc_in,
    output logic        mdr_in,
    output logic        ir_in,
    output logic        y_in,
    output logic        zlow_in,
    output logic        inc_pc,
    output logic        read,
    output logic [4:0]  alu_sel,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic        halted,
    output logic        bad_op,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StT0     = 3'd1,
        StT1     = 3'd2,
        StT2     = 3'd3,
        StT3     = 3'd4,
        StT4     = 3'd5,
        StT5     = 3'd6,
        StHalted = 3'd7
    } state_e;

    localparam logic [4:0] OpHalt = 5'b11011;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic [4:0] alu_code;
    logic       op_valid;
    logic       op_unary;
    logic       unused_ir;

    assign op        = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];

    always_comb begin
        alu_code = 5'd0;
        op_valid = 1'b1;
        op_unary = 1'b0;
        case (op)
            5'b00011: alu_code = 5'b00000;
            5'b00100: alu_code = 5'b00001;
            5'b00101: alu_code = 5'b00010;
            5'b00110: alu_code = 5'b00011;
            5'b00111: alu_code = 5'b00100;
            5'b01000: alu_code = 5'b00101;
            5'b01001: alu_code = 5'b00110;
            5'b01010: alu_code = 5'b01000;
            5'b01011: alu_code = 5'b00111;
            5'b10001: begin
                alu_code = 5'b01001;
                op_unary = 1'b1;
            end
            5'b10010: begin
                alu_code = 5'b01010;
                op_unary = 1'b1;
            end
            default:  op_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= StIdle;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_out   = 1'b0;
        zlow_out = 1'b0;
        mdr_out  = 1'b0;
        mar_in   = 1'b0;
        pc_in    = 1'b0;
        mdr_in   = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        zlow_in  = 1'b0;
        inc_pc   = 1'b0;
        read     = 1'b0;
        alu_sel  = 5'd0;
        reg_in   = 16'd0;
        reg_out  = 16'd0;
        halted   = 1'b0;
        bad_op   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StT0;
            end
            StT0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                zlow_in = 1'b1;
                state_d = StT1;
            end
            StT1: begin
                read   = 1'b1;
                mdr_in = 1'b1;
                // Incremented PC is committed only alongside the valid memory word.
                if (mem_ready) begin
                    zlow_out = 1'b1;
                    pc_in    = 1'b1;
                    state_d  = StT2;
                    cnt_d    = 32'd0;
                end else if (MEM_TIMEOUT != 0 && cnt_q + 32'd1 == MEM_TIMEOUT) begin
                    bad_op  = 1'b1;
                    state_d = StHalted;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StT2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                if (op == OpHalt) begin
                    state_d = StHalted;
                end else if (!op_valid) begin
                    bad_op  = 1'b1;
                    state_d = StT0;
                end else begin
                    reg_out = 16'd1 << rb;
                    y_in    = 1'b1;
                    alu_sel = alu_code;
                    state_d = StT4;
                end
            end
            StT4: begin
                reg_out = 16'd1 << (op_unary ? rb : rc);
                alu_sel = alu_code;
                zlow_in = 1'b1;
                state_d = StT5;
            end
            StT5: begin
                zlow_out = 1'b1;
                reg_in   = 16'd1 << ra;
                alu_sel  = alu_code;
                state_d  = StT0;
            end
            StHalted: begin
                halted = 1'b1;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Cycle-level check of alu_control_sequencer against a table-driven reference
// model of the instruction phases, with directed and randomized instructions.
module tb_alu_control_sequencer;

    localparam int unsigned TO = 4;

    logic        clock = 1'b0;
    logic        clear, run, mem_ready;
    logic [31:0] ir;
    logic        pc_out, zlow_out, mdr_out, mar_in, pc_in, mdr_in, ir_in;
    logic        y_in, zlow_in, inc_pc, read, halted, bad_op;
    logic [4:0]  alu_sel;
    logic [15:0] reg_in, reg_out;
    logic [2:0]  state;

    alu_control_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .pc_out(pc_out), .zlow_out(zlow_out), .mdr_out(mdr_out), .mar_in(mar_in),
        .pc_in(pc_in), .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in), .zlow_in(zlow_in),
        .inc_pc(inc_pc), .read(read), .alu_sel(alu_sel), .reg_in(reg_in),
        .reg_out(reg_out), .halted(halted), .bad_op(bad_op), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  st;
        logic        halted, bad_op, pc_out, zlow_out, mdr_out, mar_in, pc_in;
        logic        mdr_in, ir_in, y_in, zlow_in, inc_pc, read;
        logic [4:0]  alu_sel;
        logic [15:0] reg_in, reg_out;
    } outs_t;

    // Opcode table straight from the instruction list.
    logic [4:0] alu_tab [32];
    logic       op_ok   [32];
    logic       op_un   [32];

    int          m_st, m_cnt;          // model phase: 0 idle, 1..6 T0..T5, 7 halted
    logic [31:0] mem_word;
    int          stall_left;
    logic        run_req;
    int          n_checks, n_pass, n_fail;
    int          c_read, c_pcin, c_bad, c_regin;
    logic [15:0] t3_ro, t4_ro, t5_ri;
    logic [4:0]  t4_alu;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic outs_t model_out();
        outs_t e;
        logic [4:0] op;
        e = '0;
        op = ir[31:27];
        e.st = m_st[2:0];
        case (m_st)
            1: begin e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.zlow_in = 1; end
            2: begin
                e.read = 1; e.mdr_in = 1;
                if (mem_ready) begin e.zlow_out = 1; e.pc_in = 1; end
                else if (m_cnt + 1 == int'(TO)) e.bad_op = 1;
            end
            3: begin e.mdr_out = 1; e.ir_in = 1; end
            4: begin
                if (op_ok[op]) begin
                    e.reg_out = 16'd1 << ir[22:19]; e.y_in = 1; e.alu_sel = alu_tab[op];
                end else if (op != 5'b11011) e.bad_op = 1;
            end
            5: begin
                e.reg_out = 16'd1 << (op_un[op] ? ir[22:19] : ir[18:15]);
                e.alu_sel = alu_tab[op]; e.zlow_in = 1;
            end
            6: begin e.zlow_out = 1; e.reg_in = 16'd1 << ir[26:23]; e.alu_sel = alu_tab[op]; end
            7: e.halted = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic model_next();
        logic [4:0] op;
        op = ir[31:27];
        if (clear) begin m_st = 0; m_cnt = 0; end
        else case (m_st)
            0: if (run) m_st = 1;
            2: begin
                if (mem_ready) begin m_st = 3; m_cnt = 0; end
                else if (m_cnt + 1 == int'(TO)) begin m_st = 7; m_cnt = 0; end
                else m_cnt++;
            end
            4: m_st = (op == 5'b11011) ? 7 : (op_ok[op] ? 5 : 1);
            6: m_st = 1;
            7: m_st = 7;
            default: m_st++;
        endcase
    endtask

    task automatic step();
        outs_t got, exp;
        logic ld;
        #1;
        exp = model_out();
        got = '{st: state, halted: halted, bad_op: bad_op, pc_out: pc_out,
                zlow_out: zlow_out, mdr_out: mdr_out, mar_in: mar_in, pc_in: pc_in,
                mdr_in: mdr_in, ir_in: ir_in, y_in: y_in, zlow_in: zlow_in,
                inc_pc: inc_pc, read: read, alu_sel: alu_sel, reg_in: reg_in,
                reg_out: reg_out};
        check("outputs", 64'(got), 64'(exp));
        check("bus_drivers_le1", 64'(32'(pc_out) + 32'(zlow_out) + 32'(mdr_out)
              + $countones(reg_out) <= 1), 64'd1);
        check("reg_in_onehot0", 64'($countones(reg_in) <= 1), 64'd1);
        if (got.read) c_read++;
        if (got.pc_in) c_pcin++;
        if (got.bad_op) c_bad++;
        if (|got.reg_in) c_regin++;
        if (got.st == 3'd4) t3_ro = got.reg_out;
        if (got.st == 3'd5) begin t4_ro = got.reg_out; t4_alu = got.alu_sel; end
        if (got.st == 3'd6) t5_ri = got.reg_in;
        ld = exp.ir_in;
        @(posedge clock);
        model_next();
        @(negedge clock);
        if (ld) ir = mem_word;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (m_st == 2) begin
                mem_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            run = (m_st == 0) ? run_req : 1'($urandom_range(0, 1));
            step();
        end
    endtask

    // Runs one instruction from T0 until the next T0 (or HALTED).
    task automatic do_instr(input logic [31:0] w, input int stalls);
        int k;
        mem_word = w;
        stall_left = stalls;
        k = 0;
        do begin
            cycles(1);
            k++;
        end while (!(m_st == 1 || m_st == 7) && k < 60);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'(0)};
    endfunction

    initial begin
        logic [4:0] ops [11];
        logic [4:0] codes [11];
        logic [4:0] pool [13];
        ops   = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                  5'b01001, 5'b01010, 5'b01011, 5'b10001, 5'b10010};
        codes = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                  5'b00110, 5'b01000, 5'b00111, 5'b01001, 5'b01010};
        for (int i = 0; i < 32; i++) begin alu_tab[i] = 5'd0; op_ok[i] = 0; op_un[i] = 0; end
        for (int i = 0; i < 11; i++) begin
            alu_tab[ops[i]] = codes[i]; op_ok[ops[i]] = 1; pool[i] = ops[i];
        end
        op_un[5'b10001] = 1; op_un[5'b10010] = 1;
        pool[11] = 5'b11111; pool[12] = 5'b00000;
        n_checks = 0; n_pass = 0; n_fail = 0;
        ir = 32'd0; mem_word = 32'd0; stall_left = 0;
        clear = 1; run = 0; mem_ready = 0; run_req = 0;
        @(posedge clock);
        @(negedge clock);
        m_st = 0; m_cnt = 0;
        cycles(1);                       // reset state checked with clear still high
        clear = 0;
        run_req = 1;
        cycles(1);

        do_instr(32'h5332_0000, 0);      // ROR R6, R6, R4
        check("ror_t3_reg_out", 64'(t3_ro), 64'h0040);
        check("ror_t4_reg_out", 64'(t4_ro), 64'h0010);
        check("ror_t4_alu_sel", 64'(t4_alu), 64'b01000);
        check("ror_t5_reg_in", 64'(t5_ri), 64'h0040);
        check("ror_then_t0", 64'(state), 64'd1);

        c_read = 0; c_pcin = 0;
        do_instr(mk(5'b00011, 4'd1, 4'd2, 4'd3), 3);
        check("stall_read_cycles", 64'(c_read), 64'd4);
        check("stall_pc_in_pulses", 64'(c_pcin), 64'd1);

        c_bad = 0; c_regin = 0;
        do_instr(mk(5'b11111, 4'd3, 4'd4, 4'd5), 0);
        check("badop_pulses", 64'(c_bad), 64'd1);
        check("badop_no_reg_in", 64'(c_regin), 64'd0);
        check("badop_then_t0", 64'(state), 64'd1);

        do_instr(mk(5'b10010, 4'd2, 4'd5, 4'd9), 1);
        check("not_t4_reg_out", 64'(t4_ro), 64'h0020);
        check("not_t4_alu_sel", 64'(t4_alu), 64'b01010);
        check("not_t5_reg_in", 64'(t5_ri), 64'h0004);

        for (int n = 0; n < 30; n++) begin
            do_instr(mk(pool[$urandom_range(0, 12)], 4'($urandom), 4'($urandom),
                        4'($urandom)), $urandom_range(0, 3));
        end

        mem_word = mk(5'b00100, 4'd7, 4'd8, 4'd9);
        for (int k = 0; k < 20 && m_st != 5; k++) cycles(1);
        check("reached_t4", 64'(state), 64'd5);
        clear = 1;
        cycles(1);
        clear = 0; run_req = 0;
        cycles(1);
        check("clear_to_idle", 64'(state), 64'd0);
        check("clear_no_reg_in", 64'(reg_in), 64'd0);
        cycles(2);
        run_req = 1;
        cycles(1);
        check("restart_t0", 64'(state), 64'd1);

        do_instr(mk(5'b11011, 4'd0, 4'd0, 4'd0), 0);
        cycles(3);
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_state", 64'(state), 64'd7);

        clear = 1; cycles(1); clear = 0; cycles(1);
        c_bad = 0;
        do_instr(mk(5'b00011, 4'd1, 4'd1, 4'd1), 10);
        cycles(4);
        check("timeout_badop_once", 64'(c_bad), 64'd1);
        check("timeout_halted", 64'(halted), 64'd1);
        check("timeout_state", 64'(state), 64'd7);
        clear = 1; cycles(1); clear = 0; cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
